// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - streams a contiguous run of SRAM words onto a valid/ready output
// A 2-entry buffer absorbs the SRAM's one-cycle read latency and sink backpressure.
module sram_stream_reader #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 3,
    parameter int LEN_WIDTH     = ADDRESS_WIDTH + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]     length,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] sram_address,
    output logic                     sram_chip_sel,
    output logic                     sram_write_en,
    output logic                     sram_out_en,
    input  logic [DATA_WIDTH-1:0]    sram_data_out,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_last
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                         state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]       rd_addr_q, rd_addr_d;
    logic [LEN_WIDTH-1:0]           issue_cnt_q, issue_cnt_d;
    logic [LEN_WIDTH-1:0]           beat_cnt_q, beat_cnt_d;
    logic                           inflight_q;
    logic [1:0][DATA_WIDTH-1:0]     buf_data_q;
    logic [1:0]                     buf_last_q;
    logic                           wr_ptr_q, rd_ptr_q;
    logic [1:0]                     occ_q;

    logic issue, pop, push;

    assign m_valid = (occ_q != 2'd0);
    assign pop     = m_valid && m_ready;
    assign push    = inflight_q;

    // Words already committed (buffered or in flight) minus this cycle's pop must leave room.
    assign issue = (state_q == READ) &&
                   (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    assign sram_chip_sel = issue;
    assign sram_out_en   = issue;
    assign sram_write_en = 1'b0;
    assign sram_address  = rd_addr_q;

    assign m_data = buf_data_q[rd_ptr_q];
    assign m_last = m_valid && buf_last_q[rd_ptr_q];
    assign busy   = (state_q == READ) || (state_q == DRAIN);
    assign done   = (state_q == DONE);

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_addr_d   = base_addr;
                    issue_cnt_d = length;
                    beat_cnt_d  = length;
                    state_d     = (length == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (issue) begin
                    rd_addr_d   = rd_addr_q + ADDRESS_WIDTH'(1);
                    issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
                    if (issue_cnt_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Beats only land outside IDLE, so this never collides with the load above.
        if (push) begin
            beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= issue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data_q <= '0;
            buf_last_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            if (push) begin
                buf_data_q[wr_ptr_q] <= sram_data_out;
                buf_last_q[wr_ptr_q] <= (beat_cnt_q == LEN_WIDTH'(1));
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- Read-side initiator for the single-port `sram` block. It drives chip select, write enable, output enable and address to stream a contiguous run of words out of the SRAM.
- Data leaves on a valid/ready output stream, so the neural-network layer datapath pulls weights and activations without knowing SRAM timing.
- Handles the SRAM's one-cycle registered read latency and downstream backpressure with a 2-entry output buffer.

Parameters:
- DATA_WIDTH, 16: word width; must match the SRAM.
- ADDRESS_WIDTH, 3: SRAM address width; RAM_DEPTH = 2^ADDRESS_WIDTH.
- LEN_WIDTH, ADDRESS_WIDTH+1: width of the transfer length field, which allows 0..RAM_DEPTH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- base_addr  input  ADDRESS_WIDTH  first word address, captured with start.
- length  input  LEN_WIDTH  number of words to read, captured with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the transfer completes.
- sram_address  output  ADDRESS_WIDTH  SRAM address.
- sram_chip_sel  output  1  SRAM chip select.
- sram_write_en  output  1  SRAM write enable, constant 0.
- sram_out_en  output  1  SRAM output enable.
- sram_data_out  input  DATA_WIDTH  signed SRAM read data, valid the cycle after a read is sampled.
- m_valid  output  1  stream data valid.
- m_ready  input  1  stream sink ready.
- m_data  output  DATA_WIDTH  signed stream data, bit-exact copy of the SRAM word.
- m_last  output  1  high with the final word of the transfer.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, m_valid=0, m_last=0, m_data=0.
  - sram_chip_sel=0, sram_out_en=0, sram_address=0.
  - Buffer emptied, in-flight flag cleared, counters cleared.
  - Reset mid-transfer aborts the transfer with no done pulse.
- States: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 captures base_addr and length.
    - length=0 goes directly to DONE.
    - Otherwise goes to READ with rd_addr=base_addr, issue_cnt=length, beat_cnt=length.
  - READ: issues reads; moves to DRAIN when the last read has been issued (issue_cnt reaches 0).
  - DRAIN: no further reads; moves to DONE on the handshake of the word with m_last=1.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - busy=1 in READ and DRAIN.
  - start in any state other than IDLE is ignored.
- Read issue:
  - issue = (state==READ) && (occ + inflight - pop < 2), where occ is buffer occupancy (0..2), inflight is the registered previous issue, and pop = m_valid && m_ready.
  - sram_chip_sel = sram_out_en = issue. This is combinational from registered state and m_ready; no other input reaches these signals.
  - sram_address = rd_addr (registered).
  - On issue: rd_addr increments modulo RAM_DEPTH (7 wraps to 0) and issue_cnt decrements.
- Capture: inflight <= issue. When inflight=1, sram_data_out is pushed into the buffer at the end of that cycle. The buffer never overflows under the issue rule.
- Output:
  - m_valid = occ>0; m_data and m_last come from the buffer head.
  - m_last is the beat whose beat_cnt was 1 at push.
  - Data and m_last are held stable while m_valid=1 and m_ready=0.
  - Push and pop in the same cycle keep occ unchanged.
- Latency and throughput:
  - start sampled at end of cycle 0; first issue in cycle 1; first m_valid in cycle 3.
  - With m_ready held at 1: one word per cycle.
  - done is asserted the cycle after the m_last handshake.

Test Plan:
- Contiguous read: SRAM preloaded with mem[i]=i*3; start with base_addr=2, length=4, m_ready=1 → m_data 6, 9, 12, 15 in consecutive cycles 3-6; m_last on 15; done in cycle 7; busy high cycles 1-6.
- Wrap-around: base_addr=6, length=4 → addresses 6, 7, 0, 1 issued in that order; data matches; m_last on the word from address 1.
- Backpressure: length=8 with m_ready toggling 1,0,0,1,... → no word lost or duplicated, m_data stable while stalled, sram_chip_sel never asserted with occ+inflight-pop ≥ 2; all 8 words delivered in order.
- Edge lengths: length=0 → no sram_chip_sel, done pulses in cycle 1, busy stays 0. Length=8 (full depth) with base_addr=5 → all 8 words delivered, exactly 8 issues.
- Signed data and control: mem holds 16'h8000 and 16'hFFFF → delivered bit-exact. A start pulsed during READ is ignored. sram_write_en observed 0 throughout.
- Reset mid-operation: drop rst_n in cycle 4 of a length=6 transfer → all outputs 0 immediately without waiting for a clock edge. After release, a new transfer with base_addr=0, length=2 completes normally with no stale buffered data.
